// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - golden-trace record layout, kind and error encodings
// Shared by the trace checker and the retirement logger.
package trace_pkg;

   localparam int REC_W        = 52;
   localparam int REC_KIND_LSB = 48;
   localparam int REC_PC_LSB   = 32;
   localparam int REC_ADDR_LSB = 16;
   localparam int REC_DATA_LSB = 0;

   typedef enum logic [3:0] {
      KIND_SUB  = 4'd0,
      KIND_MOVL = 4'd1,
      KIND_MOVH = 4'd2,
      KIND_LD   = 4'd3,
      KIND_ST   = 4'd4,
      KIND_JZ   = 4'd5,
      KIND_JNZ  = 4'd6,
      KIND_JS   = 4'd7,
      KIND_JNS  = 4'd8,
      KIND_END  = 4'hF
   } traceKind_t;

   localparam logic [3:0] END_KIND = KIND_END;

   localparam logic [2:0] ERR_NONE     = 3'd0;
   localparam logic [2:0] ERR_MISMATCH = 3'd1;
   localparam logic [2:0] ERR_OVERRUN  = 3'd2;
   localparam logic [2:0] ERR_STARVE   = 3'd3;
   localparam logic [2:0] ERR_SHORT    = 3'd4;

   typedef struct packed {
      logic [3:0]  kind;
      logic [15:0] pc;
      logic [15:0] addr;
      logic [15:0] data;
   } traceRec_t;

   typedef enum logic [1:0] {
      PF_FETCH,
      PF_DRAIN,
      PF_END
   } pfState_t;

   // Jumps carry no write data, so their data field is never compared.
   function automatic logic isJump(input logic [3:0] kind);
      return (kind >= KIND_JZ) && (kind <= KIND_JNS);
   endfunction

   function automatic logic recMismatch(input traceRec_t golden, input traceRec_t seen);
      return (golden.kind != seen.kind) || (golden.pc != seen.pc) ||
             (golden.addr != seen.addr) ||
             (!isJump(golden.kind) && (golden.data != seen.data));
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous prefetch FIFO with occupancy count
// Exposes the head and the entry behind it so a same-cycle pop can look ahead.
module trace_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 52
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           pushData,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic [WIDTH-1:0]           second,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rdPtr;
   logic [PW-1:0]    wrPtr;
   logic             doPush;
   logic             doPop;

   assign empty  = (count == '0);
   assign full   = (count == CW'(DEPTH));
   assign doPop  = pop && !empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign doPush = push && (!full || doPop);
   assign head   = mem[rdPtr];
   assign second = mem[rdPtr + PW'(1)];

   always_ff @(posedge clk) begin
      if (doPush) begin
         mem[wrPtr] <= pushData;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + PW'(1);
         end
         if (doPop) begin
            rdPtr <= rdPtr + PW'(1);
         end
         count <= count + CW'(doPush) - CW'(doPop);
      end
   end

endmodule

// File: rtl/trace_checker.sv
// rtl/trace_checker.sv - compares CPU retirements against a golden trace
// Prefetches golden records into a FIFO and latches the first divergence.
module trace_checker
   import trace_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TRC_AW     = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ret_valid,
   input  logic [3:0]        ret_kind,
   input  logic [15:0]       ret_pc,
   input  logic [15:0]       ret_addr,
   input  logic [15:0]       ret_data,
   input  logic              halt,
   output logic              trc_rd,
   output logic [TRC_AW-1:0] trc_addr,
   input  logic [63:0]       trc_data,
   output logic              done,
   output logic              pass,
   output logic [2:0]        err_code,
   output logic [TRC_AW-1:0] err_index,
   output logic [REC_W-1:0]  err_expected,
   output logic [REC_W-1:0]  err_actual
);

   localparam int                CW        = $clog2(FIFO_DEPTH + 1);
   localparam logic [TRC_AW-1:0] ADDR_MAX  = '1;
   localparam traceRec_t         SYNTH_END = {END_KIND, 48'h0};

   pfState_t          state;
   pfState_t          stateNext;
   logic [TRC_AW-1:0] trcAddrQ;
   logic [TRC_AW-1:0] retCount;
   logic              inflight;
   logic              needSynth;
   logic              issueRd;
   logic              fifoPush;
   logic              fifoPop;
   logic              fifoFull;
   logic              fifoEmpty;
   logic [CW-1:0]     fifoCount;
   logic [CW:0]       reserved;
   traceRec_t         rdRec;
   traceRec_t         fifoPushData;
   traceRec_t         headRec;
   traceRec_t         secondRec;
   traceRec_t         postRec;
   traceRec_t         obsRec;
   logic              rdIsEnd;
   logic              postValid;
   logic [2:0]        errNow;
   logic [63-REC_W:0] unusedTrcBits;

   assign rdRec         = trc_data[REC_W-1:0];
   assign rdIsEnd       = (trc_data[REC_KIND_LSB +: 4] == END_KIND);
   assign unusedTrcBits = trc_data[63:REC_W];
   assign reserved      = {1'b0, fifoCount} + {{CW{1'b0}}, inflight};
   assign obsRec        = {ret_kind, ret_pc, ret_addr, ret_data};
   assign trc_rd        = issueRd;
   assign trc_addr      = trcAddrQ;

   trace_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (REC_W)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (fifoPush),
      .pushData (fifoPushData),
      .pop      (fifoPop),
      .head     (headRec),
      .second   (secondRec),
      .count    (fifoCount),
      .full     (fifoFull),
      .empty    (fifoEmpty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= PF_FETCH;
         trcAddrQ  <= '0;
         inflight  <= 1'b0;
         needSynth <= 1'b0;
      end else begin
         state    <= stateNext;
         inflight <= issueRd;
         // The last addressable record is never followed by a wrapped read.
         if (issueRd) begin
            if (trcAddrQ == ADDR_MAX) begin
               needSynth <= 1'b1;
            end else begin
               trcAddrQ <= trcAddrQ + TRC_AW'(1);
            end
         end else if (state == PF_DRAIN && ((inflight && rdIsEnd) || (!inflight && fifoPush))) begin
            needSynth <= 1'b0;
         end
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         PF_FETCH: begin
            if ((inflight && rdIsEnd) || (issueRd && trcAddrQ == ADDR_MAX)) begin
               stateNext = PF_DRAIN;
            end
         end
         PF_DRAIN: begin
            if (!inflight && (!needSynth || fifoPush)) begin
               stateNext = PF_END;
            end
         end
         default: stateNext = state;
      endcase
   end

   // Reads are throttled on slots already reserved, so a returning record always fits.
   always_comb begin
      issueRd      = 1'b0;
      fifoPush     = 1'b0;
      fifoPushData = rdRec;
      case (state)
         PF_FETCH: begin
            fifoPush = inflight;
            issueRd  = !rst && (reserved < (CW+1)'(FIFO_DEPTH)) && !(inflight && rdIsEnd);
         end
         PF_DRAIN: begin
            if (inflight) begin
               fifoPush = needSynth;
            end else if (needSynth && !fifoFull) begin
               fifoPush     = 1'b1;
               fifoPushData = SYNTH_END;
            end
         end
         default: fifoPush = 1'b0;
      endcase
   end

   always_comb begin
      fifoPop = 1'b0;
      errNow  = ERR_NONE;
      if (!done && ret_valid) begin
         if (fifoEmpty) begin
            errNow = ERR_STARVE;
         end else if (headRec.kind == END_KIND) begin
            errNow = ERR_OVERRUN;
         end else begin
            fifoPop = 1'b1;
            if (recMismatch(headRec, obsRec)) begin
               errNow = ERR_MISMATCH;
            end
         end
      end
      // Halt is judged against the head as it stands after this cycle's pop.
      if (fifoPop) begin
         postValid = (fifoCount >= CW'(2));
         postRec   = secondRec;
      end else begin
         postValid = !fifoEmpty;
         postRec   = headRec;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done         <= 1'b0;
         pass         <= 1'b0;
         err_code     <= ERR_NONE;
         err_index    <= '0;
         err_expected <= '0;
         err_actual   <= '0;
         retCount     <= '0;
      end else if (!done) begin
         if (fifoPop) begin
            retCount <= retCount + TRC_AW'(1);
         end
         if (errNow != ERR_NONE) begin
            done         <= 1'b1;
            pass         <= 1'b0;
            err_code     <= errNow;
            err_index    <= retCount;
            err_expected <= (errNow == ERR_STARVE) ? '0 : headRec;
            err_actual   <= obsRec;
         end else if (halt) begin
            done <= 1'b1;
            if (postValid && postRec.kind == END_KIND) begin
               pass <= 1'b1;
            end else begin
               pass         <= 1'b0;
               err_code     <= ERR_SHORT;
               err_index    <= retCount + TRC_AW'(fifoPop);
               err_expected <= postValid ? postRec : '0;
               err_actual   <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_trace_checker.sv
// tb/tb_trace_checker.sv - randomized and directed bench for trace_checker
// A trace-index model predicts the verdict registers every cycle.
module tb_trace_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ret_valid = 1'b0;
   logic [3:0]  ret_kind = '0;
   logic [15:0] ret_pc = '0;
   logic [15:0] ret_addr = '0;
   logic [15:0] ret_data = '0;
   logic        halt = 1'b0;
   logic        trc_rd;
   logic [11:0] trc_addr;
   logic [63:0] trc_data = '0;
   logic        done;
   logic        pass;
   logic [2:0]  err_code;
   logic [11:0] err_index;
   logic [51:0] err_expected;
   logic [51:0] err_actual;

   trace_checker #(.FIFO_DEPTH(4), .TRC_AW(12)) dut (
      .clk          (clk),
      .rst          (rst),
      .ret_valid    (ret_valid),
      .ret_kind     (ret_kind),
      .ret_pc       (ret_pc),
      .ret_addr     (ret_addr),
      .ret_data     (ret_data),
      .halt         (halt),
      .trc_rd       (trc_rd),
      .trc_addr     (trc_addr),
      .trc_data     (trc_data),
      .done         (done),
      .pass         (pass),
      .err_code     (err_code),
      .err_index    (err_index),
      .err_expected (err_expected),
      .err_actual   (err_actual)
   );

   always #5 clk = ~clk;

   logic [63:0] gold [0:4095];
   int          traceLen = 0;

   always @(posedge clk) begin
      if (trc_rd) trc_data <= gold[trc_addr];
      else        trc_data <= {$urandom, $urandom};
   end

   int nChecks = 0;
   int nFail   = 0;
   bit chkEn   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: pending (after next edge) and committed (currently visible) verdict.
   int          mRet;
   bit          pDone, pPass, eDone, ePass;
   logic [2:0]  pCode, eCode;
   int          pIndex;
   logic [11:0] eIndex;
   logic [51:0] pExp, pAct, eExp, eAct;

   task automatic clearModel();
      mRet = 0;
      pDone = 0; pPass = 0; pCode = 0; pIndex = 0; pExp = '0; pAct = '0;
      eDone = 0; ePass = 0; eCode = 0; eIndex = '0; eExp = '0; eAct = '0;
   endtask

   task automatic setErr(input logic [2:0] code, input int idx, input logic [51:0] ex, input logic [51:0] ac);
      pDone = 1; pPass = 0; pCode = code; pIndex = idx; pExp = ex; pAct = ac;
   endtask

   task automatic modelStep(input bit rv, input logic [51:0] obs, input bit h);
      logic [51:0] g;
      bit          bad;
      if (pDone) return;
      if (rv) begin
         if (mRet >= traceLen) begin
            setErr(3'd2, mRet, (traceLen < 4096) ? gold[traceLen][51:0] : {4'hF, 48'h0}, obs);
            return;
         end
         g = gold[mRet][51:0];
         bad = (g[51:16] != obs[51:16]) || (!(g[51:48] inside {[4'd5:4'd8]}) && g[15:0] != obs[15:0]);
         if (bad) begin
            setErr(3'd1, mRet, g, obs);
            return;
         end
         mRet++;
      end
      if (h) begin
         pDone = 1;
         if (mRet == traceLen) pPass = 1;
         else setErr(3'd4, mRet, gold[mRet][51:0], '0);
      end
   endtask

   task automatic cycle(input bit rv, input logic [51:0] obs, input bit h);
      logic [51:0] junk;
      junk = 52'({$urandom, $urandom});
      ret_valid = rv;
      halt = h;
      {ret_kind, ret_pc, ret_addr, ret_data} = rv ? obs : junk;
      modelStep(rv, obs, h);
      @(posedge clk);
      eDone = pDone; ePass = pPass; eCode = pCode; eIndex = pIndex[11:0]; eExp = pExp; eAct = pAct;
      #1;
      ret_valid = 0;
      halt = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
   endtask

   always @(negedge clk) begin
      if (chkEn && !rst) begin
         chk("done", 64'(done), 64'(eDone));
         chk("pass", 64'(pass), 64'(ePass));
         chk("err_code", 64'(err_code), 64'(eCode));
         chk("err_index", 64'(err_index), 64'(eIndex));
         chk("err_expected", 64'(err_expected), 64'(eExp));
         chk("err_actual", 64'(err_actual), 64'(eAct));
         if (trc_rd) chk("trc_addr_past_end", 64'(int'(trc_addr) <= traceLen), 64'd1);
      end
   end

   task automatic doReset();
      chkEn = 0;
      rst = 1;
      ret_valid = 0;
      halt = 0;
      @(posedge clk); #1;
      chk("reset_trc_rd", 64'(trc_rd), 64'd0);
      chk("reset_trc_addr", 64'(trc_addr), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_err_code", 64'(err_code), 64'd0);
      @(posedge clk); #1;
      clearModel();
      rst = 0;
      chkEn = 1;
   endtask

   function automatic logic [51:0] mkRec(input logic [3:0] k, input logic [15:0] p,
                                         input logic [15:0] a, input logic [15:0] d);
      return {k, p, a, d};
   endfunction

   function automatic logic [51:0] randRec();
      return {4'($urandom_range(0, 8)), 16'($urandom), 16'($urandom), 16'($urandom)};
   endfunction

   task automatic loadRandom(input int len);
      traceLen = len;
      for (int i = 0; i < len; i++) gold[i] = {12'h0, randRec()};
      if (len < 4096) gold[len] = {12'h0, 4'hF, 16'($urandom), 16'($urandom), 16'($urandom)};
      for (int i = len + 1; i < len + 8 && i < 4096; i++) gold[i] = {12'h0, randRec()};
   endtask

   task automatic loadSmall();
      loadRandom(2);
      gold[0] = {12'h0, mkRec(4'd1, 16'h0000, 16'h0001, 16'h0012)};
      gold[1] = {12'h0, mkRec(4'd4, 16'h0002, 16'h0040, 16'h0012)};
   endtask

   initial begin
      logic [51:0] obs;
      logic [51:0] one;
      int          n;
      bit          halted;
      one = 52'd1;

      // Matching two-record run then halt.
      loadSmall();
      doReset(); idle(8);
      cycle(1'b1, gold[0][51:0], 1'b0);
      cycle(1'b1, gold[1][51:0], 1'b0);
      cycle(1'b0, '0, 1'b1);
      chk("t_match_done", 64'(done), 64'd1);
      chk("t_match_pass", 64'(pass), 64'd1);
      chk("t_match_code", 64'(err_code), 64'd0);

      // Store data corrupted on the second retirement.
      doReset(); idle(8);
      cycle(1'b1, gold[0][51:0], 1'b0);
      cycle(1'b1, mkRec(4'd4, 16'h0002, 16'h0040, 16'h0013), 1'b0);
      chk("t_mm_code", 64'(err_code), 64'd1);
      chk("t_mm_index", 64'(err_index), 64'd1);
      chk("t_mm_actual", 64'(err_actual[15:0]), 64'h0013);
      chk("t_mm_done", 64'(done), 64'd1);
      chk("t_mm_pass", 64'(pass), 64'd0);

      // Jump data is not compared.
      loadRandom(1);
      gold[0] = {12'h0, mkRec(4'd5, 16'h0004, 16'h0010, 16'hBEEF)};
      doReset(); idle(8);
      cycle(1'b1, mkRec(4'd5, 16'h0004, 16'h0010, 16'h0000), 1'b1);
      chk("t_jz_pass", 64'(pass), 64'd1);
      chk("t_jz_code", 64'(err_code), 64'd0);

      // Retirement in the second cycle after reset finds an empty buffer.
      loadSmall();
      doReset();
      chkEn = 0;
      cycle(1'b0, '0, 1'b0);
      cycle(1'b1, gold[0][51:0], 1'b0);
      chk("t_starve_code", 64'(err_code), 64'd3);
      chk("t_starve_index", 64'(err_index), 64'd0);
      chk("t_starve_done", 64'(done), 64'd1);

      // Overrun past the end marker, then a short run.
      doReset(); idle(8);
      cycle(1'b1, gold[0][51:0], 1'b0);
      cycle(1'b1, gold[1][51:0], 1'b0);
      cycle(1'b1, randRec(), 1'b0);
      chk("t_over_code", 64'(err_code), 64'd2);
      chk("t_over_index", 64'(err_index), 64'd2);
      chk("t_over_exp_kind", 64'(err_expected[51:48]), 64'hF);
      doReset(); idle(8);
      cycle(1'b1, gold[0][51:0], 1'b0);
      cycle(1'b0, '0, 1'b1);
      chk("t_short_code", 64'(err_code), 64'd4);
      chk("t_short_index", 64'(err_index), 64'd1);

      // 100 back-to-back retirements.
      loadRandom(100);
      doReset(); idle(8);
      for (int i = 0; i < 100; i++) cycle(1'b1, gold[i][51:0], 1'b0);
      cycle(1'b0, '0, 1'b1);
      chk("t_b2b_pass", 64'(pass), 64'd1);
      chk("t_b2b_code", 64'(err_code), 64'd0);

      // Whole address space with no marker: a synthesized end must follow.
      loadRandom(4096);
      doReset(); idle(8);
      for (int i = 0; i < 4096; i++) cycle(1'b1, gold[i][51:0], i == 4095);
      chk("t_full_pass", 64'(pass), 64'd1);
      chk("t_full_done", 64'(done), 64'd1);

      // Randomized runs: corruption, overruns, short halts, gaps, late events.
      for (int s = 0; s < 40; s++) begin
         loadRandom($urandom_range(1, 30));
         doReset(); idle(8);
         n = $urandom_range(0, traceLen + 2);
         halted = 0;
         for (int i = 0; i < n; i++) begin
            obs = (i < traceLen) ? gold[i][51:0] : randRec();
            if ($urandom_range(0, 9) == 0) obs = obs ^ (one << $urandom_range(0, 51));
            halted = (i == n - 1) && ($urandom_range(0, 2) == 0);
            cycle(1'b1, obs, halted);
            idle($urandom_range(0, 2));
         end
         if (!halted) cycle(1'b0, '0, 1'b1);
         idle(2);
         cycle(1'b1, randRec(), 1'b1);
         idle(2);
      end

      chkEn = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/trace_checker.md
TRACE_CHECKER -- requirements
Module: trace_checker

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, golden-record prefetch buffer depth (power of 2, >=2).
REQ-002 SHALL have parameter TRC_AW, default 12, golden-trace memory address width.
REQ-003 clk  in  1  single clock, all state on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 ret_valid  in  1  one instruction retired this cycle.
REQ-006 ret_kind  in  4  0 sub,1 movl,2 movh,3 ld,4 st,5 jz,6 jnz,7 js,8 jns.
REQ-007 ret_pc  in  16  PC of retiring instruction.
REQ-008 ret_addr  in  16  reg index (zero-extended), store address, or jump target.
REQ-009 ret_data  in  16  reg write data or store data; don't-care for jumps.
REQ-010 halt  in  1  CPU halted; level, sampled each cycle.
REQ-011 trc_rd  out  1  golden-trace read strobe.
REQ-012 trc_addr  out  TRC_AW  golden record index.
REQ-013 trc_data  in  64  record, valid exactly 1 cycle after trc_rd: [51:48] kind, [47:32] pc, [31:16] addr, [15:0] data; kind 4'hF = end marker.
REQ-014 done  out  1  verdict final (sticky).
REQ-015 pass  out  1  run matched trace exactly (valid when done).
REQ-016 err_code  out  3  0 none,1 mismatch,2 overrun,3 starve,4 short.
REQ-017 err_index  out  TRC_AW  retirement count at first error.
REQ-018 err_expected / err_actual  out  52 each  golden and observed {kind,pc,addr,data} at first error.

Function
REQ-019 Prefetch FSM states FETCH, DRAIN, END; FETCH issues trc_rd while (fifo_count + inflight) < FIFO_DEPTH, trc_addr incrementing by 1 per read.
REQ-020 A returned record with kind 4'hF SHALL be pushed, and the FSM SHALL go to DRAIN (no further reads; a read already in flight is discarded), then END when inflight is 0.
REQ-021 On trc_addr = 2^TRC_AW-1 issued, FSM SHALL stop fetching and push a synthesized end marker after that record (no wrap-around).
REQ-022 Steady-state throughput SHALL be one record per cycle: pop and refill in the same cycle allowed.
REQ-023 On ret_valid with non-empty FIFO, non-marker head: pop head, compare kind, pc, addr; also data except kinds 5-8.
REQ-024 Mismatch -> err_code 1; ret_valid with end marker at head -> 2 (marker not popped); ret_valid with FIFO empty -> 3.
REQ-025 First error only SHALL latch err_code/err_index/err_expected/err_actual and set done=1, pass=0; later events ignored.
REQ-026 err_index SHALL equal number of retirements compared before the failing one (first retirement = 0).
REQ-027 halt=1 with no error: head is end marker -> done=1, pass=1; otherwise (record pending or FIFO empty) -> done=1, pass=0, err_code 4.
REQ-028 ret_valid and halt in same cycle: comparison SHALL be evaluated first, halt check uses post-pop head.
REQ-029 done, pass, err_* SHALL hold until rst; FSM SHALL continue prefetch harmlessly after done.

Reset
REQ-030 rst SHALL force: FSM FETCH, trc_addr 0, trc_rd 0, FIFO empty, inflight 0, count 0, done 0, pass 0, err_code 0, err_index 0, err_expected 0, err_actual 0.
REQ-031 rst asserted mid-run SHALL discard any read returning in the following cycle.

Structure
REQ-032 Kind encodings, END_KIND, error codes, record field offsets SHALL live in shared package trace_pkg, also used by the retirement logger.
REQ-033 Prefetch buffer SHALL be sub-module trace_fifo (sync FIFO, count, full/empty, simultaneous push/pop).

Verification
REQ-034 Trace [movl r1=0x0012 @0000, st m[0040]=0x0012 @0002, END]; matching retirements then halt -> done=1, pass=1, err_code 0.
REQ-035 Same trace, second retirement data 0x0013 -> err_code 1, err_index 1, err_actual data 0x0013, done=1.
REQ-036 jz @0004 target 0010, golden data 0xBEEF vs actual 0x0000 -> no error (data ignored for jumps).
REQ-037 ret_valid in cycle 1 after rst release -> err_code 3, err_index 0.
REQ-038 Three retirements against two-record trace -> err_code 2, err_index 2; halt after first of two -> err_code 4.
REQ-039 Back-to-back ret_valid for 100 cycles against 100-record trace, FIFO_DEPTH 4 -> no starve, pass=1.
